// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point defaults, FC-layer FSM states and the 16-bit saturating narrow.
package cnn_fixed_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF  = 8;
    localparam int ACC_WIDTH_DEF  = 40;
    localparam int SAT_IN_W       = 64;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fc_state_e;

    // Clamp a wide signed value into the Q8.8 range [0x8000, 0x7FFF].
    function automatic logic [15:0] sat16(input logic signed [SAT_IN_W-1:0] v);
        if (v > 64'sd32767) begin
            return 16'h7FFF;
        end else if (v < -64'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate: acc += a*b on each enabled cycle; clear has priority.
module fc_mac
    import cnn_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one MAC time-shared over all neurons,
// weights from a 1-cycle-latency external ROM, saturated Q8.8 outputs.
module fc_layer_seq
    import cnn_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int IN_NODES   = 288,
    parameter int OUT_NODES  = 10,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [IN_NODES*DATA_WIDTH-1:0]        input_fc,
    input  logic [OUT_NODES*DATA_WIDTH-1:0]       bias_fc,
    output logic [$clog2(IN_NODES*OUT_NODES)-1:0] weight_addr,
    input  logic [DATA_WIDTH-1:0]                 weight_data,
    output logic [OUT_NODES*DATA_WIDTH-1:0]       output_fc,
    output logic                                  busy,
    output logic                                  done
);

    localparam int ADDR_W = $clog2(IN_NODES*OUT_NODES);
    localparam int IDX_W  = (IN_NODES > 1) ? $clog2(IN_NODES) : 1;
    localparam int NODE_W = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1;

    fc_state_e                        state_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [IDX_W-1:0]                 sel_q;
    logic [NODE_W-1:0]                node_q;
    logic [ADDR_W-1:0]                addr_q;
    logic [IN_NODES*DATA_WIDTH-1:0]   in_q;
    logic [OUT_NODES*DATA_WIDTH-1:0]  bias_q;
    logic [OUT_NODES*DATA_WIDTH-1:0]  out_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             acc_en_q;

    logic signed [DATA_WIDTH-1:0]     x_w;
    logic signed [DATA_WIDTH-1:0]     bias_w;
    logic signed [ACC_WIDTH-1:0]      acc_w;
    logic signed [ACC_WIDTH-1:0]      shifted_w;
    logic signed [ACC_WIDTH-1:0]      sum_w;
    logic [15:0]                      result_w;

    // sel_q trails the address by one cycle, matching the ROM read latency.
    assign x_w       = in_q[sel_q*DATA_WIDTH +: DATA_WIDTH];
    assign bias_w    = bias_q[node_q*DATA_WIDTH +: DATA_WIDTH];
    assign shifted_w = acc_w >>> FRAC_BITS;
    assign sum_w     = shifted_w + {{(ACC_WIDTH-DATA_WIDTH){bias_w[DATA_WIDTH-1]}}, bias_w};
    assign result_w  = sat16({{(SAT_IN_W-ACC_WIDTH){sum_w[ACC_WIDTH-1]}}, sum_w});

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q == WRITE),
        .en_i    (acc_en_q),
        .a_i     (x_w),
        .b_i     (weight_data),
        .acc_o   (acc_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sel_q    <= '0;
            node_q   <= '0;
            addr_q   <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_en_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            acc_en_q <= (state_q == MAC);
            sel_q    <= idx_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_q    <= input_fc;
                        bias_q  <= bias_fc;
                        idx_q   <= '0;
                        node_q  <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (idx_q == IDX_W'(IN_NODES-1)) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= WRITE;
                end
                WRITE: begin
                    out_q[node_q*DATA_WIDTH +: DATA_WIDTH] <= result_w;
                    idx_q <= '0;
                    if (node_q == NODE_W'(OUT_NODES-1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        node_q  <= node_q + NODE_W'(1);
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign weight_addr = addr_q;
    assign output_fc   = out_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: a 4x2 instance driven from a vector table and a
// default 288x10 instance checked against a behavioural reference model.
module tb_fc_layer_seq;

    localparam int S_IN  = 4;
    localparam int S_OUT = 2;
    localparam int B_IN  = 288;
    localparam int B_OUT = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        s_start;
    logic [63:0] s_in;
    logic [31:0] s_bias;
    logic [2:0]  s_addr;
    logic [15:0] s_wd;
    logic [31:0] s_out;
    logic        s_busy, s_done;
    logic [15:0] s_rom [S_IN*S_OUT];

    logic          b_start;
    logic [4607:0] b_in;
    logic [159:0]  b_bias;
    logic [11:0]   b_addr;
    logic [15:0]   b_wd;
    logic [159:0]  b_out;
    logic          b_busy, b_done;
    logic [15:0]   b_rom [B_IN*B_OUT];

    fc_layer_seq #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .IN_NODES   (S_IN),
        .OUT_NODES  (S_OUT),
        .ACC_WIDTH  (40)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .input_fc    (s_in),
        .bias_fc     (s_bias),
        .weight_addr (s_addr),
        .weight_data (s_wd),
        .output_fc   (s_out),
        .busy        (s_busy),
        .done        (s_done)
    );

    fc_layer_seq #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .IN_NODES   (B_IN),
        .OUT_NODES  (B_OUT),
        .ACC_WIDTH  (40)
    ) u_big (
        .clk         (clk),
        .reset       (reset),
        .start       (b_start),
        .input_fc    (b_in),
        .bias_fc     (b_bias),
        .weight_addr (b_addr),
        .weight_data (b_wd),
        .output_fc   (b_out),
        .busy        (b_busy),
        .done        (b_done)
    );

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) s_wd <= s_rom[s_addr];
    always @(posedge clk) b_wd <= b_rom[b_addr];

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t         vt [6];
    int           checks = 0;
    int           errors = 0;
    logic [159:0] sb_q [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string tag, output logic [159:0] e);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: actual empty required one entry", tag);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic small_run(input vec_t v, input string tag);
        int n;
        logic [159:0] e;
        for (int j = 0; j < S_IN*S_OUT; j++) s_rom[j] = v.w;
        for (int j = 0; j < S_IN; j++) s_in[j*16 +: 16] = v.x;
        s_bias = {v.b1, v.b0};
        sb_q.push_back({128'd0, v.e1, v.e0});
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        n = 1;
        chk({tag, " busy_after_start"}, 64'(s_busy), 64'd1);
        while (!s_done && n < 100) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd13);
        chk({tag, " busy_at_done"}, 64'(s_busy), 64'd0);
        sb_pop(tag, e);
        chk({tag, " out0"}, 64'(s_out[15:0]), 64'(e[15:0]));
        chk({tag, " out1"}, 64'(s_out[31:16]), 64'(e[31:16]));
        tick;
        chk({tag, " done_one_cycle"}, 64'(s_done), 64'd0);
    endtask

    task automatic big_load;
        logic [159:0] e;
        longint acc, s;
        logic signed [15:0] xv, wv, bv;
        for (int i = 0; i < B_IN; i++) b_in[i*16 +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
        for (int o = 0; o < B_OUT; o++) b_bias[o*16 +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
        for (int k = 0; k < B_IN*B_OUT; k++) b_rom[k] = 16'($urandom_range(0, 255)) - 16'd128;
        for (int o = 0; o < B_OUT; o++) begin
            acc = 0;
            for (int i = 0; i < B_IN; i++) begin
                xv = b_in[i*16 +: 16];
                wv = b_rom[o*B_IN + i];
                acc += longint'(xv) * longint'(wv);
            end
            bv = b_bias[o*16 +: 16];
            s = (acc >>> 8) + longint'(bv);
            if (s > 32767) e[o*16 +: 16] = 16'h7FFF;
            else if (s < -32768) e[o*16 +: 16] = 16'h8000;
            else e[o*16 +: 16] = s[15:0];
        end
        sb_q.push_back(e);
    endtask

    task automatic big_run(input string tag);
        int n;
        logic [159:0] e;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n = 1;
        while (!b_done && n < 4000) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd2901);
        chk({tag, " busy_at_done"}, 64'(b_busy), 64'd0);
        sb_pop(tag, e);
        for (int o = 0; o < B_OUT; o++) begin
            chk($sformatf("%s out%0d", tag, o), 64'(b_out[o*16 +: 16]), 64'(e[o*16 +: 16]));
        end
        tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, dcnt, dn;
        logic [159:0] e;

        s_start = 1'b0;
        s_in    = '0;
        s_bias  = '0;
        b_start = 1'b0;
        b_in    = '0;
        b_bias  = '0;
        for (int j = 0; j < S_IN*S_OUT; j++) s_rom[j] = '0;
        for (int j = 0; j < B_IN*B_OUT; j++) b_rom[j] = '0;

        reset = 1'b1;
        repeat (3) tick;
        chk("rst small out",  64'(s_out),  64'd0);
        chk("rst small busy", 64'(s_busy), 64'd0);
        chk("rst small done", 64'(s_done), 64'd0);
        chk("rst small addr", 64'(s_addr), 64'd0);
        chk("rst big out",    64'(b_out[63:0]), 64'd0);
        chk("rst big busy",   64'(b_busy), 64'd0);
        chk("rst big done",   64'(b_done), 64'd0);
        chk("rst big addr",   64'(b_addr), 64'd0);
        reset = 1'b0;
        tick;

        //          x         w         b0        b1        e0        e1
        vt[0] = '{16'h0100, 16'h0080, 16'h0000, 16'h0000, 16'h0200, 16'h0200};
        vt[1] = '{16'h0100, 16'hFF00, 16'h0000, 16'h0080, 16'hFC00, 16'hFC80};
        vt[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        vt[3] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
        vt[4] = '{16'h0200, 16'h0040, 16'hFF00, 16'h0100, 16'h0100, 16'h0300};
        vt[5] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
        for (int k = 0; k < 6; k++) small_run(vt[k], $sformatf("vec%0d", k));

        // Ignored mid-run start plus upstream change after capture.
        for (int j = 0; j < S_IN*S_OUT; j++) s_rom[j] = 16'h0080;
        for (int j = 0; j < S_IN; j++) s_in[j*16 +: 16] = 16'h0100;
        s_bias = '0;
        sb_q.push_back({128'd0, 16'h0200, 16'h0200});
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        n = 1;
        dcnt = 0;
        dn = 0;
        while (n < 40) begin
            if (n == 3) begin
                s_start = 1'b1;
                for (int j = 0; j < S_IN; j++) s_in[j*16 +: 16] = 16'h7FFF;
                s_bias = 32'h1234_1234;
            end else begin
                s_start = 1'b0;
            end
            tick;
            n++;
            if (s_done) begin
                dcnt++;
                if (dn == 0) dn = n;
            end
            if (n == 7) begin
                chk("partial out0_new", 64'(s_out[15:0]),  64'h0200);
                chk("partial out1_old", 64'(s_out[31:16]), 64'h0000);
            end
        end
        chk("midrun done_count", 64'(dcnt), 64'd1);
        chk("midrun done_cycle", 64'(dn),   64'd13);
        sb_pop("midrun", e);
        chk("midrun out0", 64'(s_out[15:0]),  64'(e[15:0]));
        chk("midrun out1", 64'(s_out[31:16]), 64'(e[31:16]));

        big_load;
        big_run("big1");

        // Abort a run with reset; no done may follow and outputs return to zero.
        big_load;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n = 1;
        while (n < 1000) begin
            tick;
            n++;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sb_q.delete();
        chk("abort out",  64'(b_out[63:0]), 64'd0);
        chk("abort out_hi", 64'(b_out[159:64]), 64'd0);
        chk("abort busy", 64'(b_busy), 64'd0);
        chk("abort done", 64'(b_done), 64'd0);
        chk("abort addr", 64'(b_addr), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 3000; k++) begin
            tick;
            if (b_done) dcnt++;
        end
        chk("abort no_done", 64'(dcnt), 64'd0);

        big_load;
        big_run("big_fresh");

        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
